// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: request encodings,
// divider FSM states and a small two's-complement helper.
package mdu_pkg;

  localparam int unsigned MDU_W = 32;

  // Request encodings on div_op/mul_op; 2'b11 is illegal and ignored.
  localparam logic [1:0] MDU_OP_NONE     = 2'b00;
  localparam logic [1:0] MDU_OP_UNSIGNED = 2'b01;
  localparam logic [1:0] MDU_OP_SIGNED   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_t;

  function automatic logic [MDU_W-1:0] cond_neg(input logic [MDU_W-1:0] x,
                                                input logic             neg);
    return neg ? (~x + {{(MDU_W-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/serial_divider_if.sv
// Divide request/done channel between the ALU (master) and the divider (slave).
interface serial_divider_if;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] result;
  logic        done;

  modport master (output div_op, dividend, divisor, input result, done);
  modport slave  (input div_op, dividend, divisor, output result, done);
endinterface

// File: rtl/serial_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// 34-cycle latency from accept to a new {remainder, quotient} with done high.
module serial_divider
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  serial_divider_if.slave bus
);

  div_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        done_q, done_d;

  logic        is_signed;
  logic        accept;
  logic [32:0] shifted_rem;
  logic [32:0] trial;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    is_signed   = (bus.div_op == MDU_OP_SIGNED);
    accept      = is_signed || (bus.div_op == MDU_OP_UNSIGNED);
    shifted_rem = {rem_q, quo_q[31]};
    trial       = shifted_rem - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d     = '0;
          quo_d     = cond_neg(bus.dividend, is_signed && bus.dividend[31]);
          dvs_d     = cond_neg(bus.divisor,  is_signed && bus.divisor[31]);
          neg_quo_d = is_signed && (bus.dividend[31] ^ bus.divisor[31]);
          neg_rem_d = is_signed && bus.dividend[31];
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        // A negative trial (borrow out of bit 32) means the divisor did not fit.
        rem_d = trial[32] ? shifted_rem[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        result_d = {cond_neg(rem_q, neg_rem_q), cond_neg(quo_q, neg_quo_q)};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the working registers are fully loaded on accept before any use,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvs_q     <= dvs_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: doc/serial_divider.md
# serial_divider

Iterative 32-bit MIPS DIV/DIVU responder for the ALU's divide request/done interface, one quotient bit per cycle. It latches operands on a non-zero `div_op` while idle and runs a restoring division. It drops `done` while busy, then raises it with `{remainder, quotient}` ready to commit into HI/LO. The ALU sees the commit as the rising edge of `done`.

## Interface
- No parameters; operand width fixed at 32.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `div_op` in 2: 2'b10 = signed DIV, 2'b01 = unsigned DIVU, 2'b00 = no request, 2'b11 = illegal (ignored).
- `dividend` in 32: numerator; sampled only on accept.
- `divisor` in 32: denominator; sampled only on accept.
- `result` out 64: `{remainder[31:0], quotient[31:0]}`; bits [63:32] go to HI, [31:0] to LO.
- `done` out 1: 1 = idle/result valid; 0 = division in progress.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: `done`=1.
  - `div_op` of 2'b10 or 2'b01 accepts the request. Latch operands, sign mode and a 5-bit counter = 0, then go to CALC.
  - 2'b00 or 2'b11: stay in IDLE.
- Operand prep on accept:
  - Signed mode: store |dividend| and |divisor|, plus `neg_q` = dividend[31]^divisor[31] and `neg_r` = dividend[31].
  - Unsigned mode: store raw operands; `neg_q` = `neg_r` = 0.
- CALC, one step per cycle:
  - Shift `{rem, quo}` left by 1.
  - Compute the 33-bit trial = `rem` − divisor.
  - Trial non-negative: `rem` = trial, quo[0] = 1. Otherwise keep `rem`, quo[0] = 0.
  - Counter increments each step. After the step with counter 31, go to FIX.
- FIX: negate the quotient if `neg_q`; negate the remainder if `neg_r`. Write `result`, then go to IDLE.
- `div_op` is ignored in CALC and FIX. The block has no abort input; the ALU only kills an operation via `rst`.
- Divisor zero:
  - No early exit; latency unchanged.
  - Unsigned: quotient = 32'hFFFF_FFFF, remainder = dividend.
  - Signed: the same magnitude result, then sign fix per the FIX rules (deterministic, architecturally UNPREDICTABLE).
- 32'h8000_0000 / 32'hFFFF_FFFF signed: quotient = 32'h8000_0000, remainder = 0. No trap.
- `result` changes only on the FIX→IDLE transition; it holds its previous value throughout CALC and FIX.

## Timing
- Reset values: state IDLE, `done`=1, `result`=64'h0, counter 0.
- Accept at cycle T (IDLE, valid `div_op`).
  - `done`=0 from T+1 through T+33 (32 CALC cycles, then 1 FIX cycle).
  - `done`=1 and new `result` visible at T+34.
  - Total latency: 34 cycles.
- `done` is a registered output equal to (state == IDLE), so it is low for at least 33 cycles. This guarantees the ALU sees a clean rising edge per operation.
- Back-to-back: a valid `div_op` at T+34, the first IDLE cycle, is accepted.
  - `done` is still 1 that cycle, so the ALU commits the previous result.
  - `done` falls at T+35.
- `rst` asserted in any state: next cycle is IDLE, `done`=1, `result`=0. The in-flight operation is discarded and no commit edge is produced.
- Operand inputs may change freely after the accept cycle.

## Structure
- Shared package `mdu_pkg`:
  - Op encodings `MDU_OP_NONE`=2'b00, `MDU_OP_UNSIGNED`=2'b01, `MDU_OP_SIGNED`=2'b10.
  - State enum `div_state_t` {IDLE, CALC, FIX}.
  - The multiplier uses the same op encodings.
- Single flat module. The 33-bit subtract/shift step is inline; no sub-module is warranted.

## Test plan
- Reset → `done`=1, `result`=0. Hold `div_op`=0 for 10 cycles → no change.
- DIVU 100/7 accepted at T → `done` low T+1..T+33; at T+34 `result`=`{32'd2, 32'd14}`, `done`=1.
- DIV −7/2 (32'hFFFF_FFF9, 2) → `result`=`{32'hFFFF_FFFF, 32'hFFFF_FFFD}` (rem −1, quo −3). Then DIV 7/−2 → `{32'd1, 32'hFFFF_FFFD}`.
- Divisor 0, DIVU 32'h1234_5678 → `result`=`{32'h1234_5678, 32'hFFFF_FFFF}` after 34 cycles. DIV 32'h8000_0000/32'hFFFF_FFFF → `{32'h0, 32'h8000_0000}`.
- Busy-ignore and back-to-back:
  - Pulse DIVU 9/3 during CALC → ignored; the first result is unaffected.
  - Issue DIVU 9/3 in the first IDLE cycle → accepted; result `{0, 3}` 34 cycles later.
  - Exactly two `done` rising edges in total.
- Assert `rst` at T+15 of a DIVU 50/5 → `done`=1, `result`=0 next cycle. No rising edge of `done` other than the reset return; no stale result ever appears.
